// File: rtl/icon_update_ctrl.sv
// Frame-synchronous icon location/orientation update controller with animation frame index.
// Optional PEND watchdog is built when ICON_UPD_WDOG_EN is defined.
//
// state  | meaning
// IDLE   | waiting for updReq, shadow register free
// PEND   | update held in shadow, waiting for blanking start (or watchdog)
// COMMIT | live location just updated from shadow, ack next cycle
// ACK    | updAck/clamped valid, returns to IDLE
module icon_update_ctrl #(
    parameter int V_ACTIVE    = 480,
    parameter int MAX_LOC     = 112,
    parameter int RESET_X     = 64,
    parameter int RESET_Y     = 64,
    parameter int ANIM_DIV    = 8,
    parameter int WDOG_CYCLES = 840000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixCol,
    input  logic [9:0] pixRow,
    input  logic       updReq,
    input  logic [7:0] newLocX,
    input  logic [7:0] newLocY,
    input  logic [2:0] newOrient,
    output logic       updBusy,
    output logic       updAck,
    output logic       clamped,
    output logic [7:0] locX,
    output logic [7:0] locY,
    output logic [2:0] orient,
    output logic       frameTick,
    output logic [1:0] animFrame
);

    typedef enum logic [1:0] {IDLE, PEND, COMMIT, ACK} state_t;

    localparam logic [9:0] V_ACT_ROW = 10'(V_ACTIVE);
    localparam logic [7:0] MAX8      = 8'(MAX_LOC);
    localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

    state_t     state;
    logic [7:0] shadowX;
    logic [7:0] shadowY;
    logic [2:0] shadowOrient;
    logic [7:0] frameCnt;
    logic       blankStart;
    logic       commitNow;

    assign blankStart = (pixRow == V_ACT_ROW) && (pixCol == 10'd0);

`ifdef ICON_UPD_WDOG_EN
    localparam logic [19:0] WDOG_LAST = 20'(WDOG_CYCLES - 1);

    logic [19:0] wdogCnt;
    logic        wdogExpired;

    assign wdogExpired = (wdogCnt == WDOG_LAST);
    assign commitNow   = blankStart || wdogExpired;

    always_ff @(posedge clk) begin
        if (reset || state != PEND) begin
            wdogCnt <= '0;
        end else if (!commitNow) begin
            wdogCnt <= wdogCnt + 20'd1;
        end
    end
`else
    // Without the watchdog this term is constant 0; PEND waits for blanking only.
    localparam logic WDOG_NEVER = (WDOG_CYCLES < 0);

    assign commitNow = blankStart || WDOG_NEVER;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            updBusy      <= 1'b0;
            updAck       <= 1'b0;
            clamped      <= 1'b0;
            locX         <= 8'(RESET_X);
            locY         <= 8'(RESET_Y);
            orient       <= 3'd0;
            shadowX      <= 8'd0;
            shadowY      <= 8'd0;
            shadowOrient <= 3'd0;
        end else begin
            updAck <= 1'b0;
            case (state)
                IDLE: begin
                    if (updReq) begin
                        shadowX      <= newLocX;
                        shadowY      <= newLocY;
                        shadowOrient <= newOrient;
                        updBusy      <= 1'b1;
                        state        <= PEND;
                    end
                end
                PEND: begin
                    // Live values load on the edge leaving PEND so they are visible during COMMIT.
                    if (commitNow) begin
                        locX    <= (shadowX > MAX8) ? MAX8 : shadowX;
                        locY    <= (shadowY > MAX8) ? MAX8 : shadowY;
                        orient  <= shadowOrient;
                        clamped <= (shadowX > MAX8) || (shadowY > MAX8);
                        state   <= COMMIT;
                    end
                end
                COMMIT: begin
                    updAck <= 1'b1;
                    state  <= ACK;
                end
                ACK: begin
                    updBusy <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frameTick <= 1'b0;
            frameCnt  <= 8'd0;
            animFrame <= 2'd0;
        end else begin
            frameTick <= blankStart;
            if (frameTick) begin
                if (frameCnt == ANIM_LAST) begin
                    frameCnt  <= 8'd0;
                    animFrame <= animFrame + 2'd1;
                end else begin
                    frameCnt <= frameCnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_icon_update_ctrl.sv
// Self-checking bench for icon_update_ctrl: directed scenarios plus a randomized run
// checked against a cycle-timed behavioural model of the update/animation rules.
module tb_icon_update_ctrl;

    localparam int V_ACTIVE = 480;
    localparam int MAX_LOC  = 112;
    localparam int RESET_X  = 64;
    localparam int RESET_Y  = 64;
    localparam int ANIM_DIV = 8;
    localparam int WDOG     = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] pixCol = '0;
    logic [9:0] pixRow = '0;
    logic       updReq = 1'b0;
    logic [7:0] newLocX = '0;
    logic [7:0] newLocY = '0;
    logic [2:0] newOrient = '0;
    logic       updBusy, updAck, clamped, frameTick;
    logic [7:0] locX, locY;
    logic [2:0] orient;
    logic [1:0] animFrame;

    int numChecks = 0;
    int numFails  = 0;

    always #5 clk = ~clk;

    icon_update_ctrl #(
        .V_ACTIVE(V_ACTIVE), .MAX_LOC(MAX_LOC), .RESET_X(RESET_X), .RESET_Y(RESET_Y),
        .ANIM_DIV(ANIM_DIV), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .reset(reset), .pixCol(pixCol), .pixRow(pixRow),
        .updReq(updReq), .newLocX(newLocX), .newLocY(newLocY), .newOrient(newOrient),
        .updBusy(updBusy), .updAck(updAck), .clamped(clamped),
        .locX(locX), .locY(locY), .orient(orient),
        .frameTick(frameTick), .animFrame(animFrame)
    );

    // Reference model: a held request commits on the first blank edge after capture,
    // acks one edge later and frees the shadow one edge after that.
    int         cyc = 0, capCyc = 0, commitCyc = -1, tickCount = 0;
    bit         held = 1'b0, blankNow, wdHit;
    logic [7:0] shX, shY, mLocX, mLocY;
    logic [2:0] shO, mOrient;
    logic       mBusy, mAck, mClamped, mTick;
    logic [1:0] mAnim;
    int         dutAcks = 0;

    always @(posedge clk) begin
        if (updAck === 1'b1) dutAcks++;
    end

    always @(posedge clk) begin
        cyc++;
        blankNow = (pixRow == V_ACTIVE) && (pixCol == 0);
        if (reset) begin
            held = 0; commitCyc = -1; tickCount = 0;
            mLocX = 8'(RESET_X); mLocY = 8'(RESET_Y); mOrient = 0;
            mBusy = 0; mAck = 0; mClamped = 0; mTick = 0; mAnim = 0;
        end else begin
            mAck = 0;
            if (mTick) begin
                tickCount++;
                mAnim = 2'((tickCount / ANIM_DIV) % 4);
            end
            mTick = blankNow;
            if (held) begin
                wdHit = 0;
`ifdef ICON_UPD_WDOG_EN
                wdHit = (cyc - capCyc == WDOG);
`endif
                if (commitCyc < 0) begin
                    if (blankNow || wdHit) begin
                        commitCyc = cyc;
                        mLocX    = (shX > MAX_LOC) ? 8'(MAX_LOC) : shX;
                        mLocY    = (shY > MAX_LOC) ? 8'(MAX_LOC) : shY;
                        mOrient  = shO;
                        mClamped = (shX > MAX_LOC) || (shY > MAX_LOC);
                    end
                end else if (cyc == commitCyc + 1) begin
                    mAck = 1;
                end else begin
                    held = 0; mBusy = 0; commitCyc = -1;
                end
            end else if (updReq) begin
                shX = newLocX; shY = newLocY; shO = newOrient;
                held = 1; mBusy = 1; capCyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        numChecks++; if (locX !== 8'd64) begin numFails++; $display("FAIL reset_locX got %0d want 64", locX); end
        numChecks++; if (locY !== 8'd64) begin numFails++; $display("FAIL reset_locY got %0d want 64", locY); end
        numChecks++; if (orient !== 3'd0) begin numFails++; $display("FAIL reset_orient got %0d want 0", orient); end
        numChecks++; if (animFrame !== 2'd0) begin numFails++; $display("FAIL reset_anim got %0d want 0", animFrame); end
        numChecks++; if (updBusy !== 1'b0) begin numFails++; $display("FAIL reset_busy got %b want 0", updBusy); end
        numChecks++; if (updAck !== 1'b0) begin numFails++; $display("FAIL reset_ack got %b want 0", updAck); end
    endtask

    task automatic test_deferred();
        int changed = 0;
        int acks0 = dutAcks;
        pixRow = 10'd100; pixCol = 10'd0;
        updReq = 1'b1; newLocX = 8'd20; newLocY = 8'd30; newOrient = 3'd5;
        tick();
        updReq = 1'b0; newLocX = 8'($urandom); newLocY = 8'($urandom); newOrient = 3'($urandom);
        numChecks++; if (updBusy !== 1'b1) begin numFails++; $display("FAIL deferred_busy got %b want 1", updBusy); end
        for (int r = 101; r <= 479; r++) begin
            pixRow = 10'(r); pixCol = 10'(r % 7);
            tick();
            if (locX !== 8'd64 || locY !== 8'd64 || orient !== 3'd0 || updAck !== 1'b0) changed++;
        end
        pixRow = 10'd480; pixCol = 10'd1;
        tick();
        if (locX !== 8'd64 || updAck !== 1'b0) changed++;
        numChecks++; if (changed != 0) begin numFails++; $display("FAIL deferred_hold got %0d early changes want 0", changed); end
        pixCol = 10'd0;
        tick();
        numChecks++; if (locX !== 8'd20) begin numFails++; $display("FAIL deferred_locX got %0d want 20", locX); end
        numChecks++; if (locY !== 8'd30) begin numFails++; $display("FAIL deferred_locY got %0d want 30", locY); end
        numChecks++; if (orient !== 3'd5) begin numFails++; $display("FAIL deferred_orient got %0d want 5", orient); end
        numChecks++; if (updAck !== 1'b0) begin numFails++; $display("FAIL deferred_early_ack got %b want 0", updAck); end
        pixCol = 10'd1;
        tick();
        numChecks++; if (updAck !== 1'b1) begin numFails++; $display("FAIL deferred_ack got %b want 1", updAck); end
        numChecks++; if (clamped !== 1'b0) begin numFails++; $display("FAIL deferred_clamped got %b want 0", clamped); end
        numChecks++; if (updBusy !== 1'b1) begin numFails++; $display("FAIL deferred_busy_ack got %b want 1", updBusy); end
        pixCol = 10'd2;
        tick(); tick();
        numChecks++; if (updBusy !== 1'b0) begin numFails++; $display("FAIL deferred_busy_done got %b want 0", updBusy); end
        numChecks++; if (dutAcks - acks0 != 1) begin numFails++; $display("FAIL deferred_ack_count got %0d want 1", dutAcks - acks0); end
    endtask

    task automatic test_saturation();
        pixRow = 10'd200; pixCol = 10'd0;
        updReq = 1'b1; newLocX = 8'd200; newLocY = 8'd112; newOrient = 3'd3;
        tick();
        updReq = 1'b0;
        pixRow = 10'd480; pixCol = 10'd0;
        tick();
        pixRow = 10'd0;
        numChecks++; if (locX !== 8'd112) begin numFails++; $display("FAIL sat_locX got %0d want 112", locX); end
        numChecks++; if (locY !== 8'd112) begin numFails++; $display("FAIL sat_locY got %0d want 112", locY); end
        numChecks++; if (orient !== 3'd3) begin numFails++; $display("FAIL sat_orient got %0d want 3", orient); end
        tick();
        numChecks++; if (updAck !== 1'b1) begin numFails++; $display("FAIL sat_min_latency_ack got %b want 1", updAck); end
        numChecks++; if (clamped !== 1'b1) begin numFails++; $display("FAIL sat_clamped got %b want 1", clamped); end
        tick(); tick();
    endtask

    task automatic test_busy_holdoff();
        pixRow = 10'd10; pixCol = 10'd0;
        updReq = 1'b1; newLocX = 8'd10; newLocY = 8'd11; newOrient = 3'd2;
        tick();
        newLocX = 8'd5; newLocY = 8'd6; newOrient = 3'd7;
        pixRow = 10'd20;
        tick(); tick(); tick();
        numChecks++; if (updBusy !== 1'b1) begin numFails++; $display("FAIL hold_busy got %b want 1", updBusy); end
        pixRow = 10'd480; pixCol = 10'd0;
        tick();
        pixRow = 10'd0;
        numChecks++; if (locX !== 8'd10 || locY !== 8'd11 || orient !== 3'd2) begin
            numFails++; $display("FAIL hold_first got %0d/%0d/%0d want 10/11/2", locX, locY, orient);
        end
        tick();
        numChecks++; if (updAck !== 1'b1) begin numFails++; $display("FAIL hold_ack got %b want 1", updAck); end
        updReq = 1'b0;
        tick();
        numChecks++; if (updBusy !== 1'b0 || locX !== 8'd10) begin
            numFails++; $display("FAIL hold_idle got busy=%b locX=%0d want busy=0 locX=10", updBusy, locX);
        end
        updReq = 1'b1;
        tick();
        updReq = 1'b0;
        tick(); tick();
        pixRow = 10'd480;
        tick();
        pixRow = 10'd0;
        numChecks++; if (locX !== 8'd5 || locY !== 8'd6 || orient !== 3'd7) begin
            numFails++; $display("FAIL hold_second got %0d/%0d/%0d want 5/6/7", locX, locY, orient);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_same_cycle_blank();
        int bad = 0;
        pixRow = 10'd480; pixCol = 10'd0;
        updReq = 1'b1; newLocX = 8'd40; newLocY = 8'd50; newOrient = 3'd1;
        tick();
        updReq = 1'b0; pixRow = 10'd481;
        for (int i = 0; i < 4; i++) begin
            if (locX !== 8'd5 || updAck !== 1'b0 || updBusy !== 1'b1) bad++;
            tick();
        end
        numChecks++; if (bad != 0) begin numFails++; $display("FAIL same_blank_skipped got %0d bad cycles want 0", bad); end
        pixRow = 10'd480;
        tick();
        pixRow = 10'd0;
        numChecks++; if (locX !== 8'd40 || locY !== 8'd50) begin
            numFails++; $display("FAIL same_blank_commit got %0d/%0d want 40/50", locX, locY);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_animation();
        pixRow = 10'd0; pixCol = 10'd0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            pixRow = 10'd480;
            tick();
            pixRow = 10'd0;
            numChecks++; if (frameTick !== 1'b1) begin numFails++; $display("FAIL anim_tick k=%0d got %b want 1", k, frameTick); end
            tick();
            numChecks++; if (animFrame !== 2'((k / 8) % 4)) begin
                numFails++; $display("FAIL anim_frame k=%0d got %0d want %0d", k, animFrame, (k / 8) % 4);
            end
        end
        numChecks++; if (frameTick !== 1'b0) begin numFails++; $display("FAIL anim_tick_pulse got %b want 0", frameTick); end
    endtask

    task automatic test_reset_mid();
        int acks0;
        pixRow = 10'd5; pixCol = 10'd0;
        updReq = 1'b1; newLocX = 8'd90; newLocY = 8'd91; newOrient = 3'd6;
        tick();
        updReq = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        acks0 = dutAcks;
        pixRow = 10'd480;
        tick();
        pixRow = 10'd0;
        tick(); tick(); tick(); tick();
        numChecks++; if (dutAcks != acks0) begin numFails++; $display("FAIL midreset_ack got %0d acks want 0", dutAcks - acks0); end
        numChecks++; if (locX !== 8'd64 || locY !== 8'd64) begin
            numFails++; $display("FAIL midreset_loc got %0d/%0d want 64/64", locX, locY);
        end
        numChecks++; if (updBusy !== 1'b0) begin numFails++; $display("FAIL midreset_busy got %b want 0", updBusy); end
    endtask

`ifdef ICON_UPD_WDOG_EN
    task automatic test_watchdog();
        int k = 0;
        pixRow = 10'd0; pixCol = 10'd0;
        updReq = 1'b1; newLocX = 8'd33; newLocY = 8'd34; newOrient = 3'd4;
        tick();
        updReq = 1'b0;
        while (locX !== 8'd33 && k < WDOG + 20) begin
            tick();
            k++;
        end
        numChecks++; if (k != WDOG) begin numFails++; $display("FAIL wdog_latency got %0d cycles want %0d", k, WDOG); end
        tick();
        numChecks++; if (updAck !== 1'b1) begin numFails++; $display("FAIL wdog_ack got %b want 1", updAck); end
        tick(); tick();
    endtask
`endif

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 4000; i++) begin
            numChecks++;
            if (locX !== mLocX || locY !== mLocY || orient !== mOrient || updBusy !== mBusy ||
                updAck !== mAck || frameTick !== mTick || animFrame !== mAnim ||
                (mAck && clamped !== mClamped)) begin
                numFails++; bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle%0d got x=%0d y=%0d o=%0d b=%b a=%b c=%b t=%b f=%0d want x=%0d y=%0d o=%0d b=%b a=%b c=%b t=%b f=%0d",
                             i, locX, locY, orient, updBusy, updAck, clamped, frameTick, animFrame,
                             mLocX, mLocY, mOrient, mBusy, mAck, mClamped, mTick, mAnim);
            end
            reset = ($urandom_range(0, 299) == 0);
            updReq = ($urandom_range(0, 3) == 0);
            newLocX = 8'($urandom); newLocY = 8'($urandom); newOrient = 3'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                pixRow = 10'd480; pixCol = 10'd0;
            end else begin
                pixRow = 10'($urandom_range(0, 524));
                pixCol = 10'($urandom_range(0, 799));
                if (pixRow == 10'd480 && pixCol == 10'd0) pixCol = 10'd1;
            end
            tick();
        end
        reset = 1'b0; updReq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_deferred();
        test_saturation();
        test_busy_holdoff();
        test_same_cycle_blank();
        test_animation();
        test_reset_mid();
`ifdef ICON_UPD_WDOG_EN
        test_watchdog();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
